// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration mode constants and index-width helper
package arb_pkg;
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational fixed-priority / round-robin grant via double-width masked search
module rr_arbiter import arb_pkg::*; #(
  parameter int N_IN = 4,
  parameter int SEL_W = clog2_min1(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);
  logic [2*N_IN-1:0] req2;
  logic found;
  int start;
  assign req2 = {req, req};
  assign start = (mode == ARB_RR) ? int'(ptr) : 0;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    for (int j = 0; j < 2 * N_IN; j++)
      if (!found && j >= start && j < start + N_IN && req2[j]) begin
        found = 1'b1;
        grant_idx = SEL_W'(j % N_IN);
      end
    grant[grant_idx] = found;
  end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-input arbitrating mux with registered valid/ready output
module arb_mux import arb_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int N_IN = 4,
  parameter int SEL_W = clog2_min1(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_mode,
  input  logic                  flush,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic [SEL_W-1:0] ptr;
  logic [N_IN-1:0] grant;
  logic [SEL_W-1:0] grant_idx;
  logic load_en;
  logic xfer;
  rr_arbiter #(.N_IN(N_IN), .SEL_W(SEL_W)) u_arb (
    .req(in_valid),
    .ptr(ptr),
    .mode(arb_mode),
    .grant(grant),
    .grant_idx(grant_idx)
  );
  assign load_en = rst_n && (!out_valid || out_ready) && !flush;
  assign in_ready = load_en ? grant : '0;
  assign xfer = |in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[grant_idx*WIDTH +: WIDTH];
        out_sel <= grant_idx;
        if (arb_mode == ARB_RR)
          ptr <= (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end
endmodule
